// File: rtl/uart_rx.sv
// UART 8E1 receiver: 2-flop synchroniser, centre sampling, parity/stop checking, clean-byte LED.
// Optional RX_MAJORITY_EN: 2-of-3 majority vote over the last three synchronised samples.
module uart_rx #(
  parameter int BAUD_RATE    = 9600,
  parameter int CLK_FREQ     = 100_000_000,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int LED_HOLD     = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       led
);

  localparam int          LED_W     = $clog2(LED_HOLD + 1);
  localparam logic [13:0] BIT_LAST  = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] HALF_LAST = 14'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t             state, state_n;
  logic               rx_m, rx_s, sample;
  logic [13:0]        clk_count, cnt_n;
  logic [2:0]         bit_index, idx_n;
  logic [7:0]         shift_reg, shift_n, data_n;
  logic               par_bit, par_n, perr_n, ferr_n, valid_n;
  logic [LED_W-1:0]   led_counter, led_n;

  // Both flops idle high so leaving reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef RX_MAJORITY_EN
  logic rx_d1, rx_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  assign sample = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clk_count   <= '0;
      bit_index   <= '0;
      shift_reg   <= '0;
      par_bit     <= 1'b0;
      data_out    <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      rx_valid    <= 1'b0;
      led_counter <= '0;
    end else begin
      state       <= state_n;
      clk_count   <= cnt_n;
      bit_index   <= idx_n;
      shift_reg   <= shift_n;
      par_bit     <= par_n;
      data_out    <= data_n;
      parity_err  <= perr_n;
      frame_err   <= ferr_n;
      rx_valid    <= valid_n;
      led_counter <= led_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = clk_count + 14'd1;
    idx_n   = bit_index;
    shift_n = shift_reg;
    par_n   = par_bit;
    data_n  = data_out;
    perr_n  = parity_err;
    ferr_n  = frame_err;
    valid_n = 1'b0;
    led_n   = (led_counter != '0) ? led_counter - LED_W'(1) : '0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        // A start edge that is gone by mid-bit is treated as line noise.
        if (clk_count == HALF_LAST) begin
          cnt_n = '0;
          if (!sample) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (clk_count == BIT_LAST) begin
          cnt_n              = '0;
          shift_n[bit_index] = sample;
          idx_n              = bit_index + 3'd1;
          if (bit_index == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (clk_count == BIT_LAST) begin
          cnt_n   = '0;
          par_n   = sample;
          state_n = STOP;
        end
      end
      STOP: begin
        // Leaving at the stop-bit centre lets a back-to-back start be caught.
        if (clk_count == BIT_LAST) begin
          cnt_n   = '0;
          data_n  = shift_reg;
          perr_n  = (^shift_reg) ^ par_bit;
          ferr_n  = ~sample;
          valid_n = 1'b1;
          state_n = sample ? IDLE : BRK;
          if (sample && !((^shift_reg) ^ par_bit)) led_n = LED_W'(LED_HOLD);
        end
      end
      BRK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);
  assign led     = (led_counter != '0);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART serial receiver; the receive-side counterpart of the team's 8E1 transmitter (start, 8 data LSB-first, even parity, 1 stop).
- Sits between the board RX pin and user logic.
- Synchronises the asynchronous line, validates start/parity/stop, and presents each byte with a one-cycle valid pulse plus error flags.
- Drives a status LED on each clean byte.

Parameters:
- BAUD_RATE, 9600, line bit rate
- CLK_FREQ, 100_000_000, clk frequency in Hz
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (10416), clk cycles per bit; may be overridden directly; legal range 8..16383
- LED_HOLD, 5_000_000, cycles LED stays on after a clean byte (50 ms)

Ports:
- clk  input  1  100 MHz system clock
- rst  input  1  synchronous active-high reset
- rx  input  1  asynchronous UART serial input, idle high
- data_out  output  8  last received byte
- rx_valid  output  1  one-cycle pulse when data_out/error flags update
- rx_busy  output  1  high while a frame is in progress
- parity_err  output  1  even-parity mismatch on last frame
- frame_err  output  1  stop bit sampled 0 on last frame
- led  output  1  high for LED_HOLD cycles after an error-free byte

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: data_out=0, rx_valid=0, rx_busy=0, parity_err=0, frame_err=0, led=0, state=IDLE, counters=0.
  - Both synchroniser flops reset to 1, so no false start occurs after reset.
  - Reset mid-frame abandons the frame; no rx_valid is produced.
- Input path: 2-flop synchroniser; all logic uses rx_s, the second flop output.
- clk_count is 14 bits; bit_index is 3 bits; HALF = CLKS_PER_BIT/2 (truncating).
- IDLE: rx_busy=0. When rx_s==0, go to START with clk_count=0.
- START: count up.
  - At clk_count==HALF-1: if rx_s==0, go to DATA with clk_count=0 and bit_index=0.
  - Otherwise treat it as a glitch: go to IDLE with no outputs changed.
- DATA: at clk_count==CLKS_PER_BIT-1, shift_reg[bit_index] <= sample, clk_count=0, bit_index+1.
  - After bit 7, go to PARITY.
  - Sample points therefore land at bit centres.
- PARITY: at CLKS_PER_BIT-1, latch par_bit, clk_count=0, go to STOP.
- STOP: at CLKS_PER_BIT-1, on that edge:
  - data_out <= shift_reg
  - parity_err <= (^shift_reg) ^ par_bit
  - frame_err <= ~sample
  - rx_valid <= 1
  - next state: IDLE if sample==1, else BREAK
- rx_valid is high exactly one cycle, always, including on errored frames. Flags and data_out hold until the next rx_valid.
- BREAK: wait until rx_s==1, then IDLE. No new start is detected while in BREAK.
- rx_busy=1 in START, DATA, PARITY, STOP, BREAK.
- Latency: rx_valid rises 2 (sync) + HALF + 10*CLKS_PER_BIT + 1 cycles after the rx falling edge.
- Back-to-back frames: the next start bit may fall immediately after the stop-bit centre. IDLE is re-entered before the stop bit ends, so no gap is needed.
- LED: on rx_valid with both error flags 0, led_counter <= LED_HOLD. led = (led_counter!=0), and the counter decrements to 0. A new clean byte reloads the counter.

Optional Feature:
- Macro: RX_MAJORITY_EN.
- Defined: every sample (start verify, data, parity, stop) is the 2-of-3 majority of rx_s at count values T-3, T-2, T-1, where T is HALF or CLKS_PER_BIT. Decisions are still taken at T-1, so latency is unchanged. Rejects single-cycle glitches at the sample point.
- Undefined: single sample of rx_s at T-1; no extra registers.

Test Plan:
- Sim with CLKS_PER_BIT=16, LED_HOLD=100.
- Send 0xA5, parity 0, stop 1 -> one rx_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, led high for 100 cycles.
- Send 0x3C with parity bit 1 (wrong) -> data_out=0x3C, parity_err=1, frame_err=0, led stays 0.
- Send 0x81 with stop bit 0, hold rx low 40 cycles -> frame_err=1, rx_busy stays 1 until rx returns high, no second rx_valid.
- rx low pulse of 5 cycles -> START aborts, rx_valid never asserts, rx_busy returns 0 within 12 cycles.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses 176 cycles apart, correct data, no errors. Also loop back from the transmitter at the default parameters with 0x55.
- Assert rst for 1 cycle during DATA bit 4 of a 0x5A frame -> all outputs 0 next cycle, no rx_valid. A following 0x12 frame is received correctly.
